// File: rtl/multicycle_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_sequencer_if
// Brief    : Instruction fields, memory handshake and control word bundle
// Revision : 1.0
// ============================================================================
interface multicycle_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       Op;
    logic [5:0]       Funct;
    logic             Zero;
    logic             MemReady;
    logic             PCWrite;
    logic             IRWrite;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             RegWrite;
    logic [1:0]       RegDst;
    logic [1:0]       MemtoReg;
    logic             ALUSrcA;
    logic             ALUSrc_sa;
    logic [1:0]       ALUSrcB;
    logic             ExtZero;
    logic [3:0]       ALUControl;
    logic [1:0]       PCSource;
    logic             Retire;
    logic             Trap;
    logic [1:0]       TrapCause;
    logic [CNT_W-1:0] InstrCount;

    // master = sequencer, slave = datapath/memory side
    modport master (
        input  Op, Funct, Zero, MemReady,
        output PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst,
               MemtoReg, ALUSrcA, ALUSrc_sa, ALUSrcB, ExtZero, ALUControl,
               PCSource, Retire, Trap, TrapCause, InstrCount
    );

    modport slave (
        output Op, Funct, Zero, MemReady,
        input  PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst,
               MemtoReg, ALUSrcA, ALUSrc_sa, ALUSrcB, ExtZero, ALUControl,
               PCSource, Retire, Trap, TrapCause, InstrCount
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_sequencer
// Brief    : Multi-cycle MIPS control FSM with memory stalls, retire counter
//            and sticky trap on illegal opcode or memory timeout
// Revision : 1.0
// ============================================================================
module multicycle_sequencer #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 32
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    multicycle_sequencer_if.master bus
);

    localparam logic [3:0] c_FETCH  = 4'd0;
    localparam logic [3:0] c_DECODE = 4'd1;
    localparam logic [3:0] c_MEMADR = 4'd2;
    localparam logic [3:0] c_MEMRD  = 4'd3;
    localparam logic [3:0] c_MEMWB  = 4'd4;
    localparam logic [3:0] c_MEMWR  = 4'd5;
    localparam logic [3:0] c_EXEC_R = 4'd6;
    localparam logic [3:0] c_RWB    = 4'd7;
    localparam logic [3:0] c_EXEC_I = 4'd8;
    localparam logic [3:0] c_IWB    = 4'd9;
    localparam logic [3:0] c_BRANCH = 4'd10;
    localparam logic [3:0] c_JUMP   = 4'd11;
    localparam logic [3:0] c_JR     = 4'd12;
    localparam logic [3:0] c_TRAP   = 4'd13;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_ANDI  = 6'h0c;
    localparam logic [5:0] c_OP_ORI   = 6'h0d;
    localparam logic [5:0] c_OP_XORI  = 6'h0e;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2b;
    localparam logic [5:0] c_FN_JR    = 6'h08;

    localparam logic [3:0] c_ALU_ADD = 4'b0000;
    localparam logic [3:0] c_ALU_SUB = 4'b0001;
    localparam logic [3:0] c_ALU_AND = 4'b0010;
    localparam logic [3:0] c_ALU_NOR = 4'b0011;
    localparam logic [3:0] c_ALU_OR  = 4'b0100;
    localparam logic [3:0] c_ALU_XOR = 4'b0101;
    localparam logic [3:0] c_ALU_SLL = 4'b0110;
    localparam logic [3:0] c_ALU_SRL = 4'b0111;
    localparam logic [3:0] c_ALU_SRA = 4'b1000;
    localparam logic [3:0] c_ALU_BEQ = 4'b1001;
    localparam logic [3:0] c_ALU_BNE = 4'b1010;
    localparam logic [3:0] c_ALU_SLT = 4'b1011;

    localparam logic [1:0] c_CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] c_CAUSE_TIMEOUT = 2'd2;

    // Last stalled cycle index at which a still-low MemReady traps
    localparam logic [9:0] c_WAIT_LAST = 10'(WAIT_LIMIT - 1);

    function automatic logic f_r_valid(input logic [5:0] fn);
        case (fn)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
            6'h26, 6'h27, 6'h2a: f_r_valid = 1'b1;
            default:             f_r_valid = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] f_r_alu(input logic [5:0] fn);
        case (fn)
            6'h00, 6'h04: f_r_alu = c_ALU_SLL;
            6'h02, 6'h06: f_r_alu = c_ALU_SRL;
            6'h03, 6'h07: f_r_alu = c_ALU_SRA;
            6'h22, 6'h23: f_r_alu = c_ALU_SUB;
            6'h24:        f_r_alu = c_ALU_AND;
            6'h25:        f_r_alu = c_ALU_OR;
            6'h26:        f_r_alu = c_ALU_XOR;
            6'h27:        f_r_alu = c_ALU_NOR;
            6'h2a:        f_r_alu = c_ALU_SLT;
            default:      f_r_alu = c_ALU_ADD;
        endcase
    endfunction

    function automatic logic [3:0] f_i_alu(input logic [5:0] op);
        case (op)
            c_OP_ANDI: f_i_alu = c_ALU_AND;
            c_OP_ORI:  f_i_alu = c_ALU_OR;
            c_OP_XORI: f_i_alu = c_ALU_XOR;
            default:   f_i_alu = c_ALU_ADD;
        endcase
    endfunction

    logic [3:0]       r_state;
    logic [3:0]       w_state_next;
    logic [1:0]       w_cause_next;
    logic [9:0]       r_wait_cnt;
    logic             w_wait_state;
    logic             w_wait_hit;
    logic [5:0]       r_op;
    logic [5:0]       r_funct;
    logic             r_trap;
    logic [1:0]       r_trap_cause;
    logic [CNT_W-1:0] r_instr_count;

    logic       w_pc_write, w_ir_write, w_iord, w_mem_read, w_mem_write;
    logic       w_reg_write, w_alu_src_a, w_alu_src_sa, w_ext_zero, w_retire;
    logic [1:0] w_reg_dst, w_mem_to_reg, w_alu_src_b, w_pc_source;
    logic [3:0] w_alu_ctl;

    assign w_wait_state = (r_state == c_FETCH) || (r_state == c_MEMRD) || (r_state == c_MEMWR);
    assign w_wait_hit   = w_wait_state && !bus.MemReady && (r_wait_cnt == c_WAIT_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cause_next = 2'd0;
        case (r_state)
            c_FETCH: begin
                if (bus.MemReady) begin
                    w_state_next = c_DECODE;
                end else if (w_wait_hit) begin
                    w_state_next = c_TRAP;
                    w_cause_next = c_CAUSE_TIMEOUT;
                end
            end
            c_DECODE: begin
                case (bus.Op)
                    c_OP_LW, c_OP_SW: w_state_next = c_MEMADR;
                    c_OP_RTYPE: begin
                        if (bus.Funct == c_FN_JR) begin
                            w_state_next = c_JR;
                        end else if (f_r_valid(bus.Funct)) begin
                            w_state_next = c_EXEC_R;
                        end else begin
                            w_state_next = c_TRAP;
                            w_cause_next = c_CAUSE_ILLEGAL;
                        end
                    end
                    c_OP_ADDI, c_OP_ADDIU, c_OP_ANDI, c_OP_ORI, c_OP_XORI:
                        w_state_next = c_EXEC_I;
                    c_OP_BEQ, c_OP_BNE: w_state_next = c_BRANCH;
                    c_OP_J, c_OP_JAL:   w_state_next = c_JUMP;
                    default: begin
                        w_state_next = c_TRAP;
                        w_cause_next = c_CAUSE_ILLEGAL;
                    end
                endcase
            end
            c_MEMADR: w_state_next = (r_op == c_OP_SW) ? c_MEMWR : c_MEMRD;
            c_MEMRD, c_MEMWR: begin
                if (bus.MemReady) begin
                    w_state_next = (r_state == c_MEMRD) ? c_MEMWB : c_FETCH;
                end else if (w_wait_hit) begin
                    w_state_next = c_TRAP;
                    w_cause_next = c_CAUSE_TIMEOUT;
                end
            end
            c_EXEC_R: w_state_next = c_RWB;
            c_EXEC_I: w_state_next = c_IWB;
            c_MEMWB, c_RWB, c_IWB, c_BRANCH, c_JUMP, c_JR: w_state_next = c_FETCH;
            c_TRAP:   w_state_next = c_TRAP;
            default:  w_state_next = c_FETCH;
        endcase
    end

    always_comb begin
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 2'd0;
        w_mem_to_reg = 2'd0;
        w_alu_src_a  = 1'b0;
        w_alu_src_sa = 1'b0;
        w_alu_src_b  = 2'd0;
        w_ext_zero   = 1'b0;
        w_alu_ctl    = c_ALU_ADD;
        w_pc_source  = 2'd0;
        w_retire     = 1'b0;
        // Reset masks everything, including the FETCH read request
        if (RST_N) begin
            case (r_state)
                c_FETCH: begin
                    w_mem_read  = 1'b1;
                    w_alu_src_b = 2'd1;
                    w_pc_write  = bus.MemReady;
                    w_ir_write  = bus.MemReady;
                end
                c_DECODE: w_alu_src_b = 2'd3;
                c_MEMADR: begin
                    w_alu_src_a = 1'b1;
                    w_alu_src_b = 2'd2;
                end
                c_MEMRD: begin
                    w_mem_read = 1'b1;
                    w_iord     = 1'b1;
                end
                c_MEMWB: begin
                    w_reg_write  = 1'b1;
                    w_mem_to_reg = 2'd1;
                    w_retire     = 1'b1;
                end
                c_MEMWR: begin
                    w_mem_write = 1'b1;
                    w_iord      = 1'b1;
                    w_retire    = bus.MemReady;
                end
                c_EXEC_R: begin
                    w_alu_src_a  = 1'b1;
                    w_alu_ctl    = f_r_alu(r_funct);
                    w_alu_src_sa = (r_funct == 6'h00) || (r_funct == 6'h02) || (r_funct == 6'h03);
                end
                c_RWB: begin
                    w_reg_write = 1'b1;
                    w_reg_dst   = 2'd1;
                    w_alu_ctl   = f_r_alu(r_funct);
                    w_retire    = 1'b1;
                end
                c_EXEC_I: begin
                    w_alu_src_a = 1'b1;
                    w_alu_src_b = 2'd2;
                    w_alu_ctl   = f_i_alu(r_op);
                    w_ext_zero  = (r_op == c_OP_ANDI) || (r_op == c_OP_ORI) || (r_op == c_OP_XORI);
                end
                c_IWB: begin
                    w_reg_write = 1'b1;
                    w_alu_ctl   = f_i_alu(r_op);
                    w_retire    = 1'b1;
                end
                c_BRANCH: begin
                    w_alu_src_a = 1'b1;
                    w_alu_ctl   = (r_op == c_OP_BNE) ? c_ALU_BNE : c_ALU_BEQ;
                    w_pc_source = 2'd1;
                    w_pc_write  = bus.Zero;
                    w_retire    = 1'b1;
                end
                c_JUMP: begin
                    w_pc_source = 2'd2;
                    w_pc_write  = 1'b1;
                    w_retire    = 1'b1;
                    if (r_op == c_OP_JAL) begin
                        w_reg_write  = 1'b1;
                        w_reg_dst    = 2'd2;
                        w_mem_to_reg = 2'd2;
                    end
                end
                c_JR: begin
                    w_pc_source = 2'd3;
                    w_pc_write  = 1'b1;
                    w_retire    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wait_cnt    <= '0;
            r_op          <= '0;
            r_funct       <= '0;
            r_trap        <= 1'b0;
            r_trap_cause  <= 2'd0;
            r_instr_count <= '0;
        end else begin
            if (w_state_next != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_wait_state && !bus.MemReady) begin
                r_wait_cnt <= r_wait_cnt + 10'd1;
            end
            // Decode register freezes the instruction in flight
            if (r_state == c_DECODE) begin
                r_op    <= bus.Op;
                r_funct <= bus.Funct;
            end
            if ((r_state != c_TRAP) && (w_state_next == c_TRAP)) begin
                r_trap       <= 1'b1;
                r_trap_cause <= w_cause_next;
            end
            if (w_retire) begin
                r_instr_count <= r_instr_count + 1'b1;
            end
        end
    end

    assign bus.PCWrite    = w_pc_write;
    assign bus.IRWrite    = w_ir_write;
    assign bus.IorD       = w_iord;
    assign bus.MemRead    = w_mem_read;
    assign bus.MemWrite   = w_mem_write;
    assign bus.RegWrite   = w_reg_write;
    assign bus.RegDst     = w_reg_dst;
    assign bus.MemtoReg   = w_mem_to_reg;
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.ALUSrc_sa  = w_alu_src_sa;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.ExtZero    = w_ext_zero;
    assign bus.ALUControl = w_alu_ctl;
    assign bus.PCSource   = w_pc_source;
    assign bus.Retire     = w_retire;
    assign bus.Trap       = r_trap;
    assign bus.TrapCause  = r_trap_cause;
    assign bus.InstrCount = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_sequencer
// Brief    : Directed vector table plus hand sequences for traps and stalls
// Revision : 1.0
// ============================================================================
module tb_multicycle_sequencer;

    typedef logic [24:0] cw_t;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        mr;
        cw_t         exp;
        logic [31:0] cnt;
        string       name;
    } vec_t;

    logic CLK = 1'b0;
    logic RST_N;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    multicycle_sequencer_if #(.CNT_W(32)) bus ();

    multicycle_sequencer #(
        .WAIT_LIMIT (4),
        .CNT_W      (32)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Field order: PCWrite IRWrite IorD MemRead MemWrite RegWrite RegDst MemtoReg
    //              ALUSrcA ALUSrc_sa ALUSrcB ExtZero ALUControl PCSource Retire Trap TrapCause
    function automatic cw_t mk(input logic pcw, irw, iord, mrd, mwr, rw,
                               input logic [1:0] rdst, m2r,
                               input logic asa, sa,
                               input logic [1:0] asb,
                               input logic ext,
                               input logic [3:0] aluc,
                               input logic [1:0] pcs,
                               input logic ret, trap,
                               input logic [1:0] cause);
        return {pcw, irw, iord, mrd, mwr, rw, rdst, m2r, asa, sa, asb, ext, aluc, pcs, ret, trap, cause};
    endfunction

    function automatic cw_t actual();
        return {bus.PCWrite, bus.IRWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.RegWrite,
                bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrc_sa, bus.ALUSrcB, bus.ExtZero,
                bus.ALUControl, bus.PCSource, bus.Retire, bus.Trap, bus.TrapCause};
    endfunction

    task automatic check_cw(input string name, input cw_t exp);
        cw_t got;
        got = actual();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: control word got %07h expected %07h", name, got, exp);
        end
    endtask

    task automatic check_cnt(input string name, input logic [31:0] exp);
        checks++;
        if (bus.InstrCount !== exp) begin
            failures++;
            $display("FAIL %s: InstrCount got %0d expected %0d", name, bus.InstrCount, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, funct, input logic zero, mr,
                       input cw_t exp, input logic [31:0] cnt, input string name);
        vec_t v;
        v.op = op; v.funct = funct; v.zero = zero; v.mr = mr;
        v.exp = exp; v.cnt = cnt; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [5:0] op, funct, input logic zero, mr);
        bus.Op = op; bus.Funct = funct; bus.Zero = zero; bus.MemReady = mr;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        RST_N = 1'b0;
        #1;
        check_cw("reset_outputs", '0);
        check_cnt("reset_count", 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    initial begin
        cw_t f_go, f_stall, dec, ex_add, trap1, trap2;
        f_go    = mk(1,1,0,1,0,0, 2'd0,2'd0, 0,0, 2'd1, 0, 4'b0000, 2'd0, 0,0, 2'd0);
        f_stall = mk(0,0,0,1,0,0, 2'd0,2'd0, 0,0, 2'd1, 0, 4'b0000, 2'd0, 0,0, 2'd0);
        dec     = mk(0,0,0,0,0,0, 2'd0,2'd0, 0,0, 2'd3, 0, 4'b0000, 2'd0, 0,0, 2'd0);
        ex_add  = mk(0,0,0,0,0,0, 2'd0,2'd0, 1,0, 2'd2, 0, 4'b0000, 2'd0, 0,0, 2'd0);
        trap1   = mk(0,0,0,0,0,0, 2'd0,2'd0, 0,0, 2'd0, 0, 4'b0000, 2'd0, 0,1, 2'd1);
        trap2   = mk(0,0,0,0,0,0, 2'd0,2'd0, 0,0, 2'd0, 0, 4'b0000, 2'd0, 0,1, 2'd2);

        // add
        add(6'h00, 6'h20, 0, 1, f_go, 0, "add_fetch");
        add(6'h00, 6'h20, 0, 1, dec,  0, "add_decode");
        add(6'h00, 6'h20, 0, 1, mk(0,0,0,0,0,0, 2'd0,2'd0, 1,0, 2'd0, 0, 4'b0000, 2'd0, 0,0,2'd0), 0, "add_exec");
        add(6'h00, 6'h20, 0, 1, mk(0,0,0,0,0,1, 2'd1,2'd0, 0,0, 2'd0, 0, 4'b0000, 2'd0, 1,0,2'd0), 0, "add_rwb");
        // sll
        add(6'h00, 6'h00, 0, 1, f_go, 1, "sll_fetch");
        add(6'h00, 6'h00, 0, 1, dec,  1, "sll_decode");
        add(6'h00, 6'h00, 0, 1, mk(0,0,0,0,0,0, 2'd0,2'd0, 1,1, 2'd0, 0, 4'b0110, 2'd0, 0,0,2'd0), 1, "sll_exec");
        add(6'h00, 6'h00, 0, 1, mk(0,0,0,0,0,1, 2'd1,2'd0, 0,0, 2'd0, 0, 4'b0110, 2'd0, 1,0,2'd0), 1, "sll_rwb");
        // ori (funct irrelevant)
        add(6'h0d, 6'h3f, 0, 1, f_go, 2, "ori_fetch");
        add(6'h0d, 6'h3f, 0, 1, dec,  2, "ori_decode");
        add(6'h0d, 6'h3f, 0, 1, mk(0,0,0,0,0,0, 2'd0,2'd0, 1,0, 2'd2, 1, 4'b0100, 2'd0, 0,0,2'd0), 2, "ori_exec");
        add(6'h0d, 6'h3f, 0, 1, mk(0,0,0,0,0,1, 2'd0,2'd0, 0,0, 2'd0, 0, 4'b0100, 2'd0, 1,0,2'd0), 2, "ori_iwb");
        // lw with three stalled MEMRD cycles
        add(6'h23, 6'h00, 0, 1, f_go,   3, "lw_fetch");
        add(6'h23, 6'h00, 0, 1, dec,    3, "lw_decode");
        add(6'h23, 6'h00, 0, 1, ex_add, 3, "lw_memadr");
        for (int k = 0; k < 3; k++)
            add(6'h23, 6'h00, 0, 0, mk(0,0,1,1,0,0, 2'd0,2'd0, 0,0, 2'd0, 0, 4'b0000, 2'd0, 0,0,2'd0), 3, "lw_memrd_stall");
        add(6'h23, 6'h00, 0, 1, mk(0,0,1,1,0,0, 2'd0,2'd0, 0,0, 2'd0, 0, 4'b0000, 2'd0, 0,0,2'd0), 3, "lw_memrd_go");
        add(6'h23, 6'h00, 0, 1, mk(0,0,0,0,0,1, 2'd0,2'd1, 0,0, 2'd0, 0, 4'b0000, 2'd0, 1,0,2'd0), 3, "lw_memwb");
        // sw with one stalled MEMWR cycle
        add(6'h2b, 6'h00, 0, 1, f_go,   4, "sw_fetch");
        add(6'h2b, 6'h00, 0, 1, dec,    4, "sw_decode");
        add(6'h2b, 6'h00, 0, 1, ex_add, 4, "sw_memadr");
        add(6'h2b, 6'h00, 0, 0, mk(0,0,1,0,1,0, 2'd0,2'd0, 0,0, 2'd0, 0, 4'b0000, 2'd0, 0,0,2'd0), 4, "sw_memwr_stall");
        add(6'h2b, 6'h00, 0, 1, mk(0,0,1,0,1,0, 2'd0,2'd0, 0,0, 2'd0, 0, 4'b0000, 2'd0, 1,0,2'd0), 4, "sw_memwr_go");
        // beq taken, beq not taken, bne taken
        add(6'h04, 6'h00, 1, 1, f_go, 5, "beq1_fetch");
        add(6'h04, 6'h00, 1, 1, dec,  5, "beq1_decode");
        add(6'h04, 6'h00, 1, 1, mk(1,0,0,0,0,0, 2'd0,2'd0, 1,0, 2'd0, 0, 4'b1001, 2'd1, 1,0,2'd0), 5, "beq1_branch");
        add(6'h04, 6'h00, 0, 1, f_go, 6, "beq0_fetch");
        add(6'h04, 6'h00, 0, 1, dec,  6, "beq0_decode");
        add(6'h04, 6'h00, 0, 1, mk(0,0,0,0,0,0, 2'd0,2'd0, 1,0, 2'd0, 0, 4'b1001, 2'd1, 1,0,2'd0), 6, "beq0_branch");
        add(6'h05, 6'h00, 1, 1, f_go, 7, "bne_fetch");
        add(6'h05, 6'h00, 1, 1, dec,  7, "bne_decode");
        add(6'h05, 6'h00, 1, 1, mk(1,0,0,0,0,0, 2'd0,2'd0, 1,0, 2'd0, 0, 4'b1010, 2'd1, 1,0,2'd0), 7, "bne_branch");
        // jal, jr
        add(6'h03, 6'h00, 0, 1, f_go, 8, "jal_fetch");
        add(6'h03, 6'h00, 0, 1, dec,  8, "jal_decode");
        add(6'h03, 6'h00, 0, 1, mk(1,0,0,0,0,1, 2'd2,2'd2, 0,0, 2'd0, 0, 4'b0000, 2'd2, 1,0,2'd0), 8, "jal_jump");
        add(6'h00, 6'h08, 0, 1, f_go, 9, "jr_fetch");
        add(6'h00, 6'h08, 0, 1, dec,  9, "jr_decode");
        add(6'h00, 6'h08, 0, 1, mk(1,0,0,0,0,0, 2'd0,2'd0, 0,0, 2'd0, 0, 4'b0000, 2'd3, 1,0,2'd0), 9, "jr_jr");
        // j, with Op changed to an illegal code after DECODE
        add(6'h02, 6'h00, 0, 1, f_go, 10, "j_fetch");
        add(6'h02, 6'h00, 0, 1, dec,  10, "j_decode");
        add(6'h3f, 6'h3f, 0, 1, mk(1,0,0,0,0,0, 2'd0,2'd0, 0,0, 2'd0, 0, 4'b0000, 2'd2, 1,0,2'd0), 10, "j_jump_inflight");
        // sub with two FETCH stalls; MemReady low in EXEC_R/RWB is ignored
        add(6'h00, 6'h22, 0, 0, f_stall, 11, "sub_fetch_stall");
        add(6'h00, 6'h22, 0, 0, f_stall, 11, "sub_fetch_stall");
        add(6'h00, 6'h22, 0, 1, f_go,    11, "sub_fetch_go");
        add(6'h00, 6'h22, 0, 1, dec,     11, "sub_decode");
        add(6'h00, 6'h22, 0, 0, mk(0,0,0,0,0,0, 2'd0,2'd0, 1,0, 2'd0, 0, 4'b0001, 2'd0, 0,0,2'd0), 11, "sub_exec");
        add(6'h00, 6'h22, 0, 0, mk(0,0,0,0,0,1, 2'd1,2'd0, 0,0, 2'd0, 0, 4'b0001, 2'd0, 1,0,2'd0), 11, "sub_rwb");

        // Reset: outputs masked even with MemReady high in FETCH
        RST_N = 1'b0;
        drive(6'h00, 6'h20, 1'b1, 1'b1);
        #1;
        check_cw("reset_outputs", '0);
        check_cnt("reset_count", 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].mr);
            #1;
            check_cw($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].exp);
            check_cnt($sformatf("%s_cnt[%0d]", vecs[i].name, i), vecs[i].cnt);
            next_cycle();
        end

        // Illegal opcode traps after DECODE and stays halted
        drive(6'h3f, 6'h00, 1'b0, 1'b1);
        #1;
        check_cnt("count_after_stream", 32'd12);
        check_cw("illegal_fetch", f_go);
        next_cycle();
        check_cw("illegal_decode", dec);
        next_cycle();
        for (int k = 0; k < 20; k++) begin
            drive(6'(k), 6'h20, k[0], k[1]);
            #1;
            check_cw($sformatf("trap_hold[%0d]", k), trap1);
            check_cnt($sformatf("trap_count_frozen[%0d]", k), 32'd12);
            next_cycle();
        end

        // Reset mid-trap, then FETCH timeout after 4 stalled cycles
        drive(6'h00, 6'h20, 1'b0, 1'b0);
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            #1;
            check_cw($sformatf("timeout_stall[%0d]", k), f_stall);
            next_cycle();
        end
        #1;
        check_cw("timeout_trap", trap2);
        check_cnt("timeout_count", 32'd0);

        // Ready on the 4th FETCH cycle wins over the timeout
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            #1;
            check_cw($sformatf("limit_stall[%0d]", k), f_stall);
            next_cycle();
        end
        bus.MemReady = 1'b1;
        #1;
        check_cw("limit_ready", f_go);
        next_cycle();
        check_cw("limit_decode", dec);
        next_cycle();
        next_cycle();
        check_cw("limit_rwb", mk(0,0,0,0,0,1, 2'd1,2'd0, 0,0, 2'd0, 0, 4'b0000, 2'd0, 1,0,2'd0));
        next_cycle();
        check_cnt("limit_count", 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
